// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF spiking layer.
// State enum, register offsets, saturating add.
package snn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_LEAK,
    S_FIRE
  } state_t;

  // Offsets relative to N_IN*N_NEUR (first non-weight address)
  localparam int OFF_THRESH = 0;
  localparam int OFF_LEAK   = 1;
  localparam int OFF_REFRAC = 2;
  localparam int OFF_MODE   = 3;

  // Signed add clamped to the limits of a w-bit signed value (w <= 31)
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)
      sat_add = signed'(hi[31:0]);
    else if (s < lo)
      sat_add = signed'(lo[31:0]);
    else
      sat_add = signed'(s[31:0]);
  endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// One LIF neuron: membrane potential, refractory counter, spike flag.
// Ports: clk/rst_n, i_state/i_idx from FSM, i_snap/i_w/cfg regs in, o_spike out.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = 8,
  parameter int V_WIDTH = 12,
  parameter int IDX_W   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  state_t                           i_state,
  input  logic [IDX_W-1:0]                 i_idx,
  input  logic [N_IN-1:0]                  i_snap,
  input  logic [N_IN-1:0][W_WIDTH-1:0]     i_w,
  input  logic [V_WIDTH-2:0]               i_thresh,
  input  logic [V_WIDTH-2:0]               i_leak,
  input  logic [3:0]                       i_refrac,
  input  logic                             i_mode,
  output logic                             o_spike
);

  localparam logic signed [V_WIDTH-1:0] VZ = '0;

  logic signed [V_WIDTH-1:0] r_v;
  logic [3:0]                r_cnt;
  logic                      r_spike;

  logic [W_WIDTH-1:0]        w_wsel;
  logic signed [31:0]        w_v32;
  logic signed [31:0]        w_w32;
  logic signed [31:0]        w_sum32;
  logic signed [V_WIDTH-1:0] w_acc;
  logic signed [V_WIDTH-1:0] w_thr;
  logic signed [V_WIDTH-1:0] w_lk;
  logic signed [V_WIDTH-1:0] w_dn;
  logic signed [V_WIDTH-1:0] w_up;
  logic                      w_fire;

  assign w_wsel  = i_w[i_idx];
  assign w_v32   = {{(32-V_WIDTH){r_v[V_WIDTH-1]}}, r_v};
  assign w_w32   = {{(32-W_WIDTH){w_wsel[W_WIDTH-1]}}, w_wsel};
  assign w_sum32 = sat_add(w_v32, w_w32, V_WIDTH);
  assign w_acc   = w_sum32[V_WIDTH-1:0];
  assign w_thr   = $signed({1'b0, i_thresh});
  assign w_lk    = $signed({1'b0, i_leak});
  // Both stay in range: v>0 minus nonneg, v<0 plus nonneg
  assign w_dn    = r_v - w_lk;
  assign w_up    = r_v + w_lk;
  assign w_fire  = (r_v >= w_thr) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_cnt   <= '0;
      r_spike <= 1'b0;
    end else begin
      case (i_state)
        S_ACCUM: begin
          if (r_cnt == 4'd0 && i_snap[i_idx])
            r_v <= w_acc;
        end
        S_LEAK: begin
          if (r_v > VZ)
            r_v <= (w_dn > VZ) ? w_dn : VZ;
          else if (r_v < VZ)
            r_v <= (w_up < VZ) ? w_up : VZ;
        end
        S_FIRE: begin
          r_spike <= w_fire;
          if (w_fire) begin
            r_v   <= i_mode ? (r_v - w_thr) : VZ;
            r_cnt <= i_refrac;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_spike = r_spike;

endmodule

// File: rtl/snn_lif_array.sv
// Fully connected LIF layer: timestep FSM, config register file, neurons.
// Ports: clk/rst_n, tick/spikes_in -> spikes_out/busy/done, cfg_* reg port.
module snn_lif_array
  import snn_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int N_NEUR     = 4,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 12,
  parameter int ADDR_W     = 8,
  parameter int THRESH_DEF = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [N_IN-1:0]    spikes_in,
  output logic [N_NEUR-1:0]  spikes_out,
  output logic               busy,
  output logic               done,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [V_WIDTH-1:0] cfg_wdata,
  output logic [V_WIDTH-1:0] cfg_rdata
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int BASE  = N_IN * N_NEUR;

  localparam logic [ADDR_W-1:0] A_THR = ADDR_W'(BASE + OFF_THRESH);
  localparam logic [ADDR_W-1:0] A_LK  = ADDR_W'(BASE + OFF_LEAK);
  localparam logic [ADDR_W-1:0] A_RF  = ADDR_W'(BASE + OFF_REFRAC);
  localparam logic [ADDR_W-1:0] A_MD  = ADDR_W'(BASE + OFF_MODE);

  localparam logic [V_WIDTH-2:0] THR_RST = (V_WIDTH-1)'(THRESH_DEF);
  localparam logic [V_WIDTH-2:0] LK_RST  = (V_WIDTH-1)'(1);
  localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(N_IN - 1);

  state_t                                r_state;
  logic [IDX_W-1:0]                      r_idx;
  logic [N_IN-1:0]                       r_snap;
  logic                                  r_busy;
  logic                                  r_done;
  logic [N_NEUR-1:0][N_IN-1:0][W_WIDTH-1:0] r_w;
  logic [V_WIDTH-2:0]                    r_thresh;
  logic [V_WIDTH-2:0]                    r_leak;
  logic [3:0]                            r_refrac;
  logic                                  r_mode;
  logic [V_WIDTH-1:0]                    r_rdata;
  logic [V_WIDTH-1:0]                    w_rdata;
  logic [N_NEUR-1:0]                     w_spk;
  logic                                  w_unused;

  assign w_unused = cfg_wdata[V_WIDTH-1];

  // busy stays high through the done cycle so a tick there is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_snap  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (tick && !r_busy) begin
            r_snap  <= spikes_in;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (r_idx == IDX_MAX)
            r_state <= S_LEAK;
          else
            r_idx <= r_idx + IDX_W'(1);
        end
        S_LEAK:  r_state <= S_FIRE;
        S_FIRE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w      <= '0;
      r_thresh <= THR_RST;
      r_leak   <= LK_RST;
      r_refrac <= '0;
      r_mode   <= 1'b0;
    end else if (cfg_we && !r_busy) begin
      for (int n = 0; n < N_NEUR; n++)
        for (int i = 0; i < N_IN; i++)
          if (cfg_addr == ADDR_W'(n * N_IN + i))
            r_w[n][i] <= cfg_wdata[W_WIDTH-1:0];
      if (cfg_addr == A_THR) r_thresh <= cfg_wdata[V_WIDTH-2:0];
      if (cfg_addr == A_LK)  r_leak   <= cfg_wdata[V_WIDTH-2:0];
      if (cfg_addr == A_RF)  r_refrac <= cfg_wdata[3:0];
      if (cfg_addr == A_MD)  r_mode   <= cfg_wdata[0];
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < N_NEUR; n++)
      for (int i = 0; i < N_IN; i++)
        if (cfg_addr == ADDR_W'(n * N_IN + i))
          w_rdata = {{(V_WIDTH-W_WIDTH){r_w[n][i][W_WIDTH-1]}},
                     r_w[n][i]};
    if (cfg_addr == A_THR) w_rdata = {1'b0, r_thresh};
    if (cfg_addr == A_LK)  w_rdata = {1'b0, r_leak};
    if (cfg_addr == A_RF)  w_rdata = {{(V_WIDTH-4){1'b0}}, r_refrac};
    if (cfg_addr == A_MD)  w_rdata = {{(V_WIDTH-1){1'b0}}, r_mode};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= w_rdata;
  end

  for (genvar n = 0; n < N_NEUR; n++) begin : g_neur
    snn_lif_neuron #(
      .N_IN    (N_IN),
      .W_WIDTH (W_WIDTH),
      .V_WIDTH (V_WIDTH),
      .IDX_W   (IDX_W)
    ) u_neuron (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_state  (r_state),
      .i_idx    (r_idx),
      .i_snap   (r_snap),
      .i_w      (r_w[n]),
      .i_thresh (r_thresh),
      .i_leak   (r_leak),
      .i_refrac (r_refrac),
      .i_mode   (r_mode),
      .o_spike  (w_spk[n])
    );
  end

  assign spikes_out = w_spk;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_rdata  = r_rdata;

endmodule

// File: tb/tb_snn_lif_array.sv
// Directed bench for snn_lif_array (4 in, 4 neurons, 8b weights, 12b v).
// Hand-computed expectations; membrane values observed hierarchically.
module tb_snn_lif_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  spikes_in = '0;
  logic [3:0]  spikes_out;
  logic        busy;
  logic        done;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic [11:0] cfg_rdata;

  int n_vec = 0;
  int n_bad = 0;
  int lat;
  int pre [4];
  int rv;
  int c;
  int dn;

  logic signed [11:0] tv [4];

  always #5 clk = ~clk;

  snn_lif_array dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .spikes_in  (spikes_in),
    .spikes_out (spikes_out),
    .busy       (busy),
    .done       (done),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata)
  );

  assign tv[0] = dut.g_neur[0].u_neuron.r_v;
  assign tv[1] = dut.g_neur[1].u_neuron.r_v;
  assign tv[2] = dut.g_neur[2].u_neuron.r_v;
  assign tv[3] = dut.g_neur[3].u_neuron.r_v;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = a[7:0];
    cfg_wdata = d[11:0];
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input int a, output int d);
    cfg_addr = a[7:0];
    @(negedge clk);
    d = int'($signed(cfg_rdata));
  endtask

  // One timestep; pre[] holds v after LEAK, before FIRE
  task automatic step(input logic [3:0] sp);
    int k;
    tick      = 1'b1;
    spikes_in = sp;
    @(negedge clk);
    tick      = 1'b0;
    spikes_in = '0;
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 5)
        for (int j = 0; j < 4; j++) pre[j] = int'(tv[j]);
    end
    lat = k;
    if (k >= 30) chk("step_timeout", k, 6);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_spk", int'(spikes_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rdata", int'(cfg_rdata), 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(16, rv); chk("rst_thresh", rv, 64);
    rd(17, rv); chk("rst_leak", rv, 1);
    rd(19, rv); chk("rst_mode", rv, 0);

    // Basic fire and latency
    wr(0, 70);
    wr(20, 99);
    rd(0, rv);  chk("rd_w00", rv, 70);
    rd(20, rv); chk("rd_unmapped", rv, 0);
    step(4'b0001);
    chk("t1_lat", lat, 6);
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_spk", int'(spikes_out), 1);
    chk("t1_v0", int'(tv[0]), 0);

    // Mode 0 vs mode 1
    do_reset();
    for (int i = 0; i < 4; i++) wr(4 + i, 30);
    wr(17, 0);
    step(4'b1111);
    chk("m0_pre_v1", pre[1], 120);
    chk("m0_spk", int'(spikes_out), 2);
    chk("m0_v1", int'(tv[1]), 0);
    do_reset();
    for (int i = 0; i < 4; i++) wr(4 + i, 30);
    wr(17, 0);
    wr(19, 1);
    step(4'b1111);
    chk("m1_spk", int'(spikes_out), 2);
    chk("m1_v1", int'(tv[1]), 56);

    // Leak, positive weight
    do_reset();
    wr(8, 20);
    wr(17, 5);
    for (int t = 1; t <= 4; t++) begin
      step(4'b0001);
      chk($sformatf("lk_v2_%0d", t), int'(tv[2]), 15 * t);
    end
    chk("lk_nospk", int'(spikes_out), 0);
    step(4'b0000);
    chk("lk_v2_decay", int'(tv[2]), 55);

    // Leak, negative weight, no zero crossing
    do_reset();
    wr(8, 12'hFEC);
    wr(17, 5);
    rd(8, rv); chk("neg_rd_w", rv, -20);
    step(4'b0001);
    chk("neg_v2_0", int'(tv[2]), -15);
    for (int t = 1; t <= 4; t++) begin
      step(4'b0000);
      chk($sformatf("neg_v2_%0d", t), int'(tv[2]),
          (t < 3) ? -15 + 5 * t : 0);
    end

    // Refractory period
    do_reset();
    wr(0, 70);
    wr(18, 2);
    step(4'b0001); chk("rf_ts1", int'(spikes_out), 1);
    step(4'b0001); chk("rf_ts2", int'(spikes_out), 0);
    chk("rf_v0_ts2", int'(tv[0]), 0);
    step(4'b0001); chk("rf_ts3", int'(spikes_out), 0);
    chk("rf_v0_ts3", int'(tv[0]), 0);
    step(4'b0001); chk("rf_ts4", int'(spikes_out), 1);

    // Saturation
    do_reset();
    for (int i = 0; i < 4; i++) wr(12 + i, 127);
    wr(16, 2047);
    wr(17, 0);
    for (int t = 1; t <= 4; t++) begin
      step(4'b1111);
      chk($sformatf("sat_v3_%0d", t), int'(tv[3]), 508 * t);
      chk($sformatf("sat_spk_%0d", t), int'(spikes_out), 0);
    end
    step(4'b1111);
    chk("sat_pre_v3", pre[3], 2047);
    chk("sat_spk", int'(spikes_out), 8);

    // Write and tick during busy, tick in done cycle
    do_reset();
    wr(0, 70);
    tick = 1'b1;
    spikes_in = 4'b0001;
    @(negedge clk);
    tick = 1'b0;
    c = 0;
    chk("b_busy", int'(busy), 1);
    cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = 12'd5;
    @(negedge clk);
    c = 1;
    cfg_we = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    c = 2;
    tick = 1'b0;
    while (!done && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("b_lat", c, 6);
    tick = 1'b1;
    spikes_in = 4'hF;
    @(negedge clk);
    tick = 1'b0;
    chk("b2b_busy", int'(busy), 0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dn += int'(done) + int'(busy);
    end
    chk("b2b_ignored", dn, 0);
    chk("b_spk", int'(spikes_out), 1);
    rd(0, rv); chk("b_wr_ignored", rv, 70);

    // Reset during ACCUM
    wr(16, 100);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ra_busy", int'(busy), 0);
    chk("ra_spk", int'(spikes_out), 0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("ra_nodone", dn, 0);
    rd(0, rv);  chk("ra_w00", rv, 0);
    rd(16, rv); chk("ra_thresh", rv, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/snn_lif_array.md
Name: snn_lif_array

Overview:
- Parametrised leaky integrate-and-fire (LIF) layer: N_IN spike inputs, fully connected to N_NEUR neurons through programmable signed weights.
- Generalises the fixed 3-in/3-out spiking core: width, channel count and reset mode are configurable, and it adds leak and a refractory period.
- Sits behind the SPI config slave, which drives the cfg_* register port, and under the chip top-level wrapper, which drives tick from a timestep divider.

Parameters:
- N_IN, 4, number of input spike channels (1..8)
- N_NEUR, 4, number of neurons / output spikes (1..8)
- W_WIDTH, 8, signed weight width
- V_WIDTH, 12, signed membrane potential width (must exceed W_WIDTH+1)
- ADDR_W, 8, config address width
- THRESH_DEF, 64, reset value of the threshold register

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  start one timestep; single-cycle pulse
- spikes_in  in  N_IN  input spikes, sampled on an accepted tick
- spikes_out  out  N_NEUR  registered output spikes of the last completed timestep
- busy  out  1  high while a timestep is in progress
- done  out  1  one-cycle pulse when spikes_out has been updated
- cfg_we  in  1  register write strobe
- cfg_addr  in  ADDR_W  register address
- cfg_wdata  in  V_WIDTH  write data; low bits used for narrower registers
- cfg_rdata  out  V_WIDTH  read data, registered, one cycle after cfg_addr

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values:
  - all weights 0; thresh=THRESH_DEF; leak=1; refrac=0; mode=0
  - all v=0; all refractory counters 0
  - spikes_out=0, busy=0, done=0, cfg_rdata=0
  - FSM returns to IDLE. Reset mid-timestep aborts it: no done pulse, spikes_out cleared.
- Address map:
  - weight[n][i] at address n*N_IN+i
  - THRESH at N_IN*N_NEUR (unsigned, V_WIDTH-1 bits)
  - LEAK at +1 (unsigned, V_WIDTH-1 bits)
  - REFRAC at +2 (4 bits)
  - MODE at +3 (bit0: 0 = reset-to-zero, 1 = subtract-threshold)
  - Unmapped writes are ignored; unmapped reads return 0.
- Config write rules:
  - Writes while busy=1 are ignored, so a timestep always uses consistent parameters.
  - Reads are allowed at any time.
- FSM states: IDLE, ACCUM, LEAK, FIRE.
- IDLE:
  - tick=1 latches spikes_in into snap, clears idx, sets busy, goes to ACCUM.
  - tick while busy is ignored; no queueing.
- ACCUM (exactly N_IN cycles, idx 0..N_IN-1):
  - Every non-refractory neuron n adds sign-extended weight[n][idx] when snap[idx]=1.
  - Result saturates at the signed V_WIDTH limits.
  - Refractory neurons hold v.
- LEAK (1 cycle):
  - v>0: v = max(v-leak, 0)
  - v<0: v = min(v+leak, 0)
  - v=0: unchanged
- FIRE (1 cycle):
  - Spike condition: v >= thresh and refractory counter == 0.
  - On spike: spikes_out[n]=1; v=0 (mode 0) or v-thresh (mode 1); counter=refrac.
  - No spike: spikes_out[n]=0; a nonzero counter decrements by 1.
  - Then done=1, busy=0, return to IDLE.
- Latency: tick accepted at cycle T → done and new spikes_out visible at cycle T+N_IN+2. spikes_out holds until the next FIRE.
- Back-to-back: a tick arriving in the same cycle as done is ignored, because busy is still 1. The earliest accepted tick is the cycle after done.
- thresh=0 with refrac=0: every neuron with v>=0 fires every timestep (legal).

Decomposition:
- Shared package snn_pkg:
  - FSM state enum
  - register offset constants (THRESH/LEAK/REFRAC/MODE relative to N_IN*N_NEUR)
  - saturating-add function
- Sub-module snn_lif_neuron: one neuron's v register, refractory counter, saturate/leak/fire datapath. Controlled by state and idx.
- The top level generates N_NEUR instances plus the FSM and register file.

Test Plan:
- Defaults, weight[0][0]=70, spikes_in=0001, one tick → done at T+N_IN+2; spikes_out=0001; v0=0.
- weight[1][*]=30, thresh=64, leak=0, spikes_in=1111 → timestep 1: v1=120, spikes_out[1]=1. Mode 1 same stimulus → v1 ends at 56.
- weight[2][0]=20, leak=5, spikes_in=0001 each tick → v2 = 15, 30, 45, 60; then a tick with spikes_in=0 → v2=55. Negative weight −20 with leak=5 decays toward 0 and never crosses it.
- refrac=2, neuron 0 fires at timestep 1 → no spike and no accumulation at timesteps 2–3; can fire at timestep 4.
- weight[3][*]=127 (W_WIDTH=8), many ticks, thresh=2047 → v3 saturates at 2047 without wrapping and fires.
- Write during busy, tick during busy, rst_n low during ACCUM → write ignored, tick ignored, no done pulse; outputs and registers return to reset values.
